// File: rtl/ham_7_4_enc_if.sv
// ham_7_4_enc_if: serial handshake between a data source and the Hamming(7,4) encoder
//   datain : serial data bit (source -> encoder)
//   dvin   : data valid, active-low (source -> encoder)
//   rdy    : encoder can accept a bit this cycle (encoder -> source)
//   code   : serial codeword bit (encoder -> sink)
//   dvout  : codeword valid, active-low (encoder -> sink)
//   ovf    : sticky overflow flag (encoder -> sink)
interface ham_7_4_enc_if;
    logic datain;
    logic dvin;
    logic rdy;
    logic code;
    logic dvout;
    logic ovf;
    modport master (output datain, dvin, input rdy, code, dvout, ovf);
    modport slave (input datain, dvin, output rdy, code, dvout, ovf);
endinterface

// File: rtl/ham_7_4_enc.sv
// ham_7_4_enc: serial Hamming(7,4) encoder, packs 4 accepted bits and shifts out p1,p2,d1,p3,d2,d3,d4
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of ham_7_4_enc_if (datain/dvin in; rdy/code/dvout/ovf out)
module ham_7_4_enc (
    input  logic         clk,
    input  logic         reset,
    ham_7_4_enc_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] asm_q, asm_d;
    logic [2:0] idx_q, idx_d;
    logic [6:0] sh_q, sh_d;
    logic [6:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       ovf_q;
    logic       accept, nib_done, last;
    logic [6:0] cw;
    assign accept   = !bus.dvin && !hold_full_q;
    assign nib_done = accept && cnt_q == 2'd3;
    assign last     = state_q == SHIFT && idx_q == 3'd6;
    // asm_q holds {d3,d2,d1}; the bit being accepted is d4; cw[0] goes out first
    assign cw = {bus.datain, asm_q[2], asm_q[1], asm_q[1] ^ asm_q[2] ^ bus.datain,
                 asm_q[0], asm_q[0] ^ asm_q[2] ^ bus.datain, asm_q[0] ^ asm_q[1] ^ bus.datain};
    assign bus.rdy   = !hold_full_q;
    assign bus.code  = sh_q[0];
    assign bus.dvout = state_q != SHIFT;
    assign bus.ovf   = ovf_q;
    always_comb begin
        cnt_d       = accept ? cnt_q + 2'd1 : cnt_q;
        asm_d       = accept ? {bus.datain, asm_q[2:1]} : asm_q;
        state_d     = state_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (state_q == SHIFT && !last) begin
            sh_d  = sh_q >> 1;
            idx_d = idx_q + 3'd1;
            if (nib_done) begin
                hold_d      = cw;
                hold_full_d = 1'b1;
            end
        end else if (last && hold_full_q) begin
            // held codeword follows back-to-back and wins over a nibble completing now
            sh_d        = hold_q;
            idx_d       = 3'd0;
            hold_full_d = 1'b0;
        end else if (nib_done) begin
            sh_d    = cw;
            idx_d   = 3'd0;
            state_d = SHIFT;
        end else begin
            sh_d    = 7'd0;
            idx_d   = 3'd0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            asm_q       <= 3'd0;
            idx_q       <= 3'd0;
            sh_q        <= 7'd0;
            hold_q      <= 7'd0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_q | (!bus.dvin && hold_full_q);
        end
    end
endmodule

// File: doc/ham_7_4_enc.md
HAM_7_4_ENC -- requirements
Module: ham_7_4_enc

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port list, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- datain  input  1  serial data bit
- dvin  input  1  data valid, active-low; datain is taken on a clk edge when dvin=0 and rdy=1
- rdy  output  1  active-high; block can accept a data bit this cycle
- code  output  1  serial Hamming(7,4) codeword bit, registered
- dvout  output  1  codeword valid, active-low, registered; this convention lets dvout drive the dvin input of ham_7_4_dec directly
- ovf  output  1  sticky overflow flag, registered

Function
REQ-003 Input grouping: accepted bits SHALL be packed four at a time into a nibble; the first accepted bit is d1, then d2, d3 and d4.
REQ-004 Parity SHALL be computed as p1=d1^d2^d4, p2=d1^d3^d4 and p3=d2^d3^d4.
REQ-005 Codeword transmit order SHALL be p1, p2, d1, p3, d2, d3, d4 (Hamming positions 1 to 7), one bit per clock.
REQ-006 The assembly counter SHALL run 0..3 and hold its value while no bit is accepted; there is no timeout, so a partial nibble waits indefinitely.
REQ-007 Buffering SHALL be an assembly register, plus one holding register (hold_full flag), plus a 7-bit output shifter.
REQ-008 Output FSM states:
- IDLE: dvout=1 and code=0.
- SHIFT: bit index 0..6; dvout=0 and code = codeword bit at that index.
REQ-009 Latency: on the edge that accepts d4, if the FSM is in IDLE or at SHIFT index 6, the codeword SHALL load into the shifter. p1 is then on code with dvout=0 immediately after that edge (1 clock of latency).
REQ-010 On the edge that accepts d4 while the FSM is in SHIFT with index below 6, the nibble SHALL move to the holding register and hold_full SHALL be set.
REQ-011 At SHIFT index 6, if hold_full=1, the held codeword SHALL load on the next edge with index reset to 0 (back-to-back, dvout stays 0) and hold_full SHALL clear. Otherwise the FSM SHALL return to IDLE.
REQ-012 If a nibble completes at index 6 while hold_full=1, the held codeword has priority. This case is unreachable because rdy=0 whenever hold_full=1.
REQ-013 rdy SHALL be combinational and equal to !hold_full.
REQ-014 A bit offered with dvin=0 while rdy=0 SHALL be discarded, SHALL NOT advance the assembly counter, and SHALL set ovf=1.
REQ-015 ovf SHALL remain 1 until reset.
REQ-016 Sustained throughput SHALL be at most 4 data bits per 7 clocks. A source that honours rdy SHALL never cause ovf.

Reset
REQ-017 While reset=1, regardless of clk, the block SHALL hold: code=0, dvout=1, rdy=1, ovf=0, assembly counter=0, hold_full=0, FSM in IDLE.
REQ-018 Reset asserted mid-nibble or mid-codeword SHALL discard all partial data. After reset releases, the next accepted bit is d1 of a new nibble.
REQ-019 The first edge after reset deassertion SHALL be able to accept a data bit.

Verification
REQ-020 Nibble 1,0,0,0 (d1 first) -> code 1,1,1,0,0,0,0 on the 7 cycles after the d4 edge, dvout=0 throughout, then dvout=1.
REQ-021 Nibbles 0,0,0,0 then 1,1,1,1 -> 0000000 then 1111111; nibble 1,0,1,1 -> 0,1,1,0,0,1,1.
REQ-022 Continuous dvin=0 with the source honouring rdy, three nibbles -> rdy drops while hold_full=1, the three codewords are sent back-to-back with no dvout gap, and ovf stays 0.
REQ-023 Source ignores rdy -> the bits offered while rdy=0 are dropped, ovf=1 until reset, and later codewords use only the accepted bits.
REQ-024 Reset pulse at SHIFT index 3 -> dvout=1 and code=0 immediately (asynchronous). A fresh nibble 1,0,1,1 then produces 0,1,1,0,0,1,1.
REQ-025 dvin=1 for 10 cycles after d2 -> no output. Supplying d3 and d4 afterwards produces the correct codeword.
REQ-026 Loop test: ham_7_4_enc code/dvout connected to ham_7_4_dec datain/dvin, with random nibbles -> the decoded output equals the input.
